// File: rtl/vend_ctrl_param.sv
// Coin vending controller: accumulates nickel/dime/quarter credit, vends one of
// NUM_PROD stocked products and pays change or refunds as one-nickel pulses.
module vend_ctrl_param #(
  parameter int NUM_PROD     = 2,
  parameter int PRICE_N      = 9,
  parameter int MAX_CREDIT_N = 13,
  parameter int STOCK_INIT   = 3,
  parameter int STOCK_W      = 4,
  parameter int CREDIT_W     = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                ni,
  input  logic                di,
  input  logic                qu,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  output logic [NUM_PROD-1:0] give,
  output logic                change,
  output logic                coin_rej,
  output logic [NUM_PROD-1:0] sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Interface semantics: ni/di/qu/cancel are single-cycle pulses, sel is a
  // level; give/change/coin_rej are single-cycle strobes, all registered.
  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  localparam int SUM_W = CREDIT_W + 3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [STOCK_W-1:0]  r_stock [NUM_PROD];
  logic [STOCK_W-1:0]  w_stock_nxt [NUM_PROD];
  logic [NUM_PROD-1:0] r_give;
  logic [NUM_PROD-1:0] w_give_nxt;
  logic [NUM_PROD-1:0] r_sold_out;
  logic [NUM_PROD-1:0] w_dec;
  logic [NUM_PROD-1:0] w_sel_oh;
  logic                w_sel_hit;
  logic                w_sel_ok;
  logic                r_change;
  logic                w_change_nxt;
  logic                r_coin_rej;
  logic                w_rej_nxt;
  logic                r_busy;
  logic                w_coin;
  logic [2:0]          w_coin_val;
  logic [SUM_W-1:0]    w_sum;

  // Coin priority qu > di > ni; losing coins vanish without a reject.
  always_comb begin
    w_coin     = ni | di | qu;
    w_coin_val = qu ? 3'd5 : (di ? 3'd2 : (ni ? 3'd1 : 3'd0));
    w_sum      = SUM_W'(r_credit) + SUM_W'(w_coin_val);
  end

  // Lowest-index pressed button whose product is still in stock.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_hit = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (!w_sel_hit && sel[i] && (r_stock[i] != '0)) begin
        w_sel_oh[i] = 1'b1;
        w_sel_hit   = 1'b1;
      end
    end
    w_sel_ok = w_sel_hit && (r_credit >= CREDIT_W'(PRICE_N));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_give_nxt   = '0;
    w_change_nxt = 1'b0;
    w_rej_nxt    = 1'b0;
    w_dec        = '0;
    case (r_state)
      S_ACCUM: begin
        if (cancel && (r_credit != '0)) begin
          w_state_nxt  = S_CHANGE;
          w_change_nxt = 1'b1;
          w_rej_nxt    = w_coin;
        end else if (w_sel_ok) begin
          w_state_nxt  = S_VEND;
          w_give_nxt   = w_sel_oh;
          w_dec        = w_sel_oh;
          w_credit_nxt = r_credit - CREDIT_W'(PRICE_N);
          w_rej_nxt    = w_coin;
        end else if (w_coin) begin
          if (w_sum <= SUM_W'(MAX_CREDIT_N)) begin
            w_credit_nxt = CREDIT_W'(w_sum);
          end else begin
            w_rej_nxt = 1'b1;
          end
        end
      end
      S_VEND: begin
        w_rej_nxt = w_coin;
        if (r_credit != '0) begin
          w_state_nxt  = S_CHANGE;
          w_change_nxt = 1'b1;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_CHANGE: begin
        // Each cycle spent here is one nickel paid out.
        w_rej_nxt = w_coin;
        if (r_credit <= CREDIT_W'(1)) begin
          w_credit_nxt = '0;
          w_state_nxt  = S_ACCUM;
        end else begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
          w_change_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_ACCUM;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      if (w_dec[i] && (r_stock[i] != '0)) begin
        w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
      end else begin
        w_stock_nxt[i] = r_stock[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= S_ACCUM;
      r_credit   <= '0;
      r_give     <= '0;
      r_change   <= 1'b0;
      r_coin_rej <= 1'b0;
      r_busy     <= 1'b0;
      r_sold_out <= '0;
      for (int i = 0; i < NUM_PROD; i++) begin
        r_stock[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_give     <= w_give_nxt;
      r_change   <= w_change_nxt;
      r_coin_rej <= w_rej_nxt;
      r_busy     <= (w_state_nxt != S_ACCUM);
      for (int i = 0; i < NUM_PROD; i++) begin
        r_stock[i]    <= w_stock_nxt[i];
        r_sold_out[i] <= (w_stock_nxt[i] == '0);
      end
    end
  end

  assign give     = r_give;
  assign change   = r_change;
  assign coin_rej = r_coin_rej;
  assign sold_out = r_sold_out;
  assign credit   = r_credit;
  assign busy     = r_busy;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a credit/stock reference model.
module tb_vend_ctrl_param;

  localparam int NUM_PROD     = 2;
  localparam int PRICE_N      = 9;
  localparam int MAX_CREDIT_N = 13;
  localparam int STOCK_INIT   = 3;
  localparam int CREDIT_W     = 4;
  localparam int OW           = 2 * NUM_PROD + CREDIT_W + 3;

  // Stimulus vector: {reset, cancel, sel[1:0], qu, di, ni}
  localparam logic [6:0] NI   = 7'h01;
  localparam logic [6:0] DI   = 7'h02;
  localparam logic [6:0] QU   = 7'h04;
  localparam logic [6:0] S0   = 7'h08;
  localparam logic [6:0] S1   = 7'h10;
  localparam logic [6:0] CAN  = 7'h20;
  localparam logic [6:0] RST  = 7'h40;
  localparam logic [6:0] IDLE = 7'h00;

  logic                CLK = 1'b0;
  logic                reset = 1'b0;
  logic                ni = 1'b0, di = 1'b0, qu = 1'b0, cancel = 1'b0;
  logic [NUM_PROD-1:0] sel = '0;
  logic [NUM_PROD-1:0] give, sold_out;
  logic                change, coin_rej, busy;
  logic [CREDIT_W-1:0] credit;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: credit, stock, and whether a vend or a payout is running.
  int                  m_credit;
  int                  m_stock [NUM_PROD];
  bit                  m_vend;
  bit                  m_ref;
  logic [NUM_PROD-1:0] e_give;
  logic                e_rej;

  vend_ctrl_param dut (
    .CLK(CLK), .reset(reset), .ni(ni), .di(di), .qu(qu), .sel(sel),
    .cancel(cancel), .give(give), .change(change), .coin_rej(coin_rej),
    .sold_out(sold_out), .credit(credit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [OW-1:0] pack_dut();
    return {give, change, coin_rej, sold_out, credit, busy};
  endfunction

  function automatic logic [OW-1:0] pack_exp();
    logic [NUM_PROD-1:0] so;
    for (int i = 0; i < NUM_PROD; i++) so[i] = (m_stock[i] == 0);
    return {e_give, m_ref, e_rej, so, CREDIT_W'(m_credit), m_vend | m_ref};
  endfunction

  task automatic model(input logic [6:0] v);
    int cv;
    int k;
    cv = v[2] ? 5 : (v[1] ? 2 : (v[0] ? 1 : 0));
    e_give = '0;
    e_rej  = 1'b0;
    if (v[6]) begin
      m_credit = 0;
      for (int i = 0; i < NUM_PROD; i++) m_stock[i] = STOCK_INIT;
      m_vend = 0;
      m_ref  = 0;
    end else if (m_vend) begin
      e_rej  = (cv != 0);
      m_vend = 0;
      m_ref  = (m_credit > 0);
    end else if (m_ref) begin
      e_rej    = (cv != 0);
      m_credit = m_credit - 1;
      m_ref    = (m_credit > 0);
    end else begin
      k = -1;
      for (int i = 0; i < NUM_PROD; i++)
        if (k < 0 && v[3+i] && m_stock[i] > 0) k = i;
      if (v[5] && m_credit > 0) begin
        m_ref = 1;
        e_rej = (cv != 0);
      end else if (k >= 0 && m_credit >= PRICE_N) begin
        e_give[k]  = 1'b1;
        m_credit   = m_credit - PRICE_N;
        m_stock[k] = m_stock[k] - 1;
        m_vend     = 1;
        e_rej      = (cv != 0);
      end else if (cv != 0) begin
        if (m_credit + cv <= MAX_CREDIT_N) m_credit = m_credit + cv;
        else e_rej = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle after it.
  task automatic step(input logic [6:0] v);
    {reset, cancel, sel, qu, di, ni} = v;
    @(posedge CLK);
    model(v);
    #1;
  endtask

  task automatic test_reset();
    step(RST);
    n_checks++;
    if (pack_dut() !== '0) $display("FAIL reset_outputs: got %h expected %h", pack_dut(), OW'(0));
    else n_pass++;
    step(IDLE);
    n_checks++;
    if (pack_dut() !== pack_exp()) $display("FAIL reset_idle: got %h expected %h", pack_dut(), pack_exp());
    else n_pass++;
  endtask

  task automatic test_exact_vend();
    logic [6:0] seq [$] = '{QU, DI, DI, S0, IDLE, IDLE};
    int peak = 0, g0 = 0, pulses = 0;
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL exact_vend cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      if (int'(credit) > peak) peak = int'(credit);
      g0 += int'(give[0]);
      pulses += int'(change);
    end
    n_checks++;
    if (peak != 9 || g0 != 1 || pulses != 0 || credit !== 4'd0)
      $display("FAIL exact_vend_summary: got peak %0d give %0d change %0d credit %0d expected 9 1 0 0", peak, g0, pulses, credit);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [6:0] seq [$] = '{QU, QU, QU, S1, IDLE, IDLE, IDLE};
    int peak = 0, g1 = 0, rej = 0, pulses = 0;
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL overflow cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      if (int'(credit) > peak) peak = int'(credit);
      g1 += int'(give[1]);
      rej += int'(coin_rej);
      pulses += int'(change);
    end
    n_checks++;
    if (peak != 10 || g1 != 1 || rej != 1 || pulses != 1 || credit !== 4'd0)
      $display("FAIL overflow_summary: got peak %0d give %0d rej %0d change %0d credit %0d expected 10 1 1 1 0", peak, g1, rej, pulses, credit);
    else n_pass++;
  endtask

  task automatic test_cancel();
    logic [6:0] seq [$] = '{DI, CAN, IDLE, IDLE, IDLE};
    int gv = 0, pulses = 0;
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL cancel cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      gv += int'(|give);
      pulses += int'(change);
    end
    n_checks++;
    if (gv != 0 || pulses != 2 || busy !== 1'b0 || credit !== 4'd0)
      $display("FAIL cancel_summary: got give %0d change %0d busy %0b credit %0d expected 0 2 0 0", gv, pulses, busy, credit);
    else n_pass++;
  endtask

  task automatic test_sold_out();
    logic [6:0] seq [$];
    int g0 = 0;
    seq.push_back(RST);
    for (int n = 0; n < 4; n++) begin
      seq.push_back(QU); seq.push_back(DI); seq.push_back(DI);
      seq.push_back(S0); seq.push_back(IDLE);
    end
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL sold_out cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      g0 += int'(give[0]);
    end
    n_checks++;
    if (g0 != 3 || sold_out !== 2'b01 || credit !== 4'd9 || busy !== 1'b0)
      $display("FAIL sold_out_summary: got give %0d sold_out %b credit %0d busy %0b expected 3 01 9 0", g0, sold_out, credit, busy);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [6:0] seq [$] = '{RST, QU, QU, DI, NI, S0 | S1 | NI | QU,
                            IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    int g0 = 0, g1 = 0, rej = 0, pulses = 0;
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL simultaneous cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      g0 += int'(give[0]);
      g1 += int'(give[1]);
      rej += int'(coin_rej);
      pulses += int'(change);
    end
    n_checks++;
    if (g0 != 1 || g1 != 0 || rej != 1 || pulses != 4 || credit !== 4'd0)
      $display("FAIL simultaneous_summary: got give0 %0d give1 %0d rej %0d change %0d credit %0d expected 1 0 1 4 0", g0, g1, rej, pulses, credit);
    else n_pass++;
  endtask

  task automatic test_reset_mid_change();
    logic [6:0] seq [$] = '{RST, QU, QU, DI, NI, S0 | S1, IDLE, IDLE, RST, IDLE, IDLE, IDLE};
    int pulses = 0;
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (pack_dut() !== pack_exp()) $display("FAIL reset_mid_change cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
      else n_pass++;
      pulses += int'(change);
    end
    n_checks++;
    if (pulses != 2 || credit !== 4'd0 || sold_out !== 2'b00 || busy !== 1'b0)
      $display("FAIL reset_mid_change_summary: got change %0d credit %0d sold_out %b busy %0b expected 2 0 00 0", pulses, credit, sold_out, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] v;
    int r;
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      v = IDLE;
      r = $urandom_range(0, 9);
      if (r == 0) v |= NI;
      else if (r == 1) v |= DI;
      else if (r == 2) v |= QU;
      else if (r == 3) v |= (NI | DI | QU);
      if ($urandom_range(0, 3) == 0) v[4:3] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) v |= CAN;
      if ($urandom_range(0, 199) == 0) v |= RST;
      step(v);
      n_checks++;
      if (pack_dut() !== pack_exp()) begin
        if (errs < 10) $display("FAIL random cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    m_credit = 0;
    m_vend   = 0;
    m_ref    = 0;
    e_give   = '0;
    e_rej    = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) m_stock[i] = STOCK_INIT;
    @(negedge CLK);
    test_reset();
    test_exact_vend();
    test_overflow();
    test_cancel();
    test_sold_out();
    test_simultaneous();
    test_reset_mid_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
